// File: rtl/ahb_lite_master_port_if.sv
// Command/response stream and AHB-Lite bus signals for ahb_lite_master_port.
// The master modport is the port's own view; the slave modport is the view of whatever drives and observes it.
interface ahb_lite_master_port_if #(
  parameter int ADDR_WIDTH = 32
);
  // Command stream
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [1:0]            cmd_size;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;

  // Response stream
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  // AHB-Lite bus
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic [31:0]           HWDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic [31:0]           HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    input  HREADY, HRESP, HRDATA,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    output HREADY, HRESP, HRDATA,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );
endinterface

// File: rtl/ahb_lite_master_port.sv
// Single-initiator AHB-Lite master: valid/ready commands in, pipelined NONSEQ SINGLE transfers out, in-order responses back.
// Optional: define AHB_MASTER_ERR_CANCEL_EN to cancel the queued address phase when the slave signals ERROR.
module ahb_lite_master_port #(
  parameter logic [3:0] HPROT_VAL  = 4'b0011,
  parameter int         ADDR_WIDTH = 32
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  ahb_lite_master_port_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Address-phase stage; its registers directly drive the bus address/control outputs.
  logic        a_valid;
  logic        a_write;
  logic [1:0]  a_size;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;

  // Data-phase stage
  logic        d_valid;
  logic        d_write;

  logic [31:0] hwdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        cmd_ready;
  logic        cmd_accept;
  logic [31:0] cmd_addr_ext;
  logic [1:0]  cmd_size_eff;

`ifdef AHB_MASTER_ERR_CANCEL_EN
  logic        err_first;
  logic        cancel_pending;
  logic        cancel_rsp;

  // First ERROR cycle of the transfer currently in its data phase.
  assign err_first = d_valid & bus.HRESP & ~bus.HREADY;
`endif

  generate
    if (ADDR_WIDTH < 32) begin : g_addr_zext
      assign cmd_addr_ext = {{(32 - ADDR_WIDTH){1'b0}}, bus.cmd_addr};
    end else begin : g_addr_trunc
      assign cmd_addr_ext = bus.cmd_addr[31:0];
    end
  endgenerate

  assign cmd_size_eff = (bus.cmd_size == 2'd3) ? SIZE_WORD : bus.cmd_size;

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
    case (size)
      SIZE_BYTE: return addr;
      SIZE_HALF: return {addr[31:1], 1'b0};
      default:   return {addr[31:2], 2'b00};
    endcase
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cmd_ready = ~a_valid | bus.HREADY;
`ifdef AHB_MASTER_ERR_CANCEL_EN
    if (err_first) cmd_ready = 1'b0;
`endif
  end

  assign cmd_accept = bus.cmd_valid & cmd_ready;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid   <= 1'b0;
      a_write   <= 1'b0;
      a_size    <= SIZE_BYTE;
      a_addr    <= '0;
      a_wdata   <= '0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      hwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef AHB_MASTER_ERR_CANCEL_EN
      cancel_pending <= 1'b0;
      cancel_rsp     <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values;
      // later assignments in this block deliberately override earlier defaults.
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;

      // Pipeline advances only when the slave completes the current data phase.
      if (bus.HREADY) begin
        d_valid <= a_valid;
        d_write <= a_write;
        hwdata  <= a_wdata;
        if (d_valid) begin
          rsp_valid <= 1'b1;
          rsp_err   <= bus.HRESP;
          rsp_rdata <= d_write ? 32'h0 : bus.HRDATA;
        end
      end

      if (cmd_accept) begin
        a_valid <= 1'b1;
        a_write <= bus.cmd_write;
        a_size  <= cmd_size_eff;
        a_addr  <= align_addr(cmd_addr_ext, cmd_size_eff);
        a_wdata <= bus.cmd_wdata;
      end else if (bus.HREADY) begin
        a_valid <= 1'b0;
      end

`ifdef AHB_MASTER_ERR_CANCEL_EN
      // Drop the queued address phase so HTRANS is IDLE in the second ERROR cycle.
      if (err_first && a_valid) begin
        a_valid        <= 1'b0;
        cancel_pending <= 1'b1;
      end
      // The cancelled command answers one cycle after the errored transfer's response.
      if (cancel_pending && d_valid && bus.HREADY) begin
        cancel_pending <= 1'b0;
        cancel_rsp     <= 1'b1;
      end
      if (cancel_rsp) begin
        cancel_rsp <= 1'b0;
        rsp_valid  <= 1'b1;
        rsp_err    <= 1'b1;
        rsp_rdata  <= '0;
      end
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready;

  assign bus.HTRANS    = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = a_addr;
  assign bus.HWRITE    = a_write;
  assign bus.HSIZE     = {1'b0, a_size};
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = hwdata;

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_ahb_lite_master_port.sv
// Directed bench for ahb_lite_master_port: the bench itself plays the AHB-Lite slave cycle by cycle.
// Error-case expectations follow AHB_MASTER_ERR_CANCEL_EN when it is defined for the build.
module tb_ahb_lite_master_port;

  logic HCLK;
  logic HRESET;

  int vectors    = 0;
  int miscompares = 0;

  ahb_lite_master_port_if #(.ADDR_WIDTH(32)) bus ();

  ahb_lite_master_port #(
    .HPROT_VAL  (4'b0011),
    .ADDR_WIDTH (32)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_cmd(input logic write, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = write;
    bus.cmd_size  = size;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
  endtask

  task automatic no_cmd();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_size  = 2'd0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
  endtask

  initial begin
    HRESET     = 1'b1;
    no_cmd();
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;

    // ---- Reset state ----
    tick();
    tick();
    check("rst_htrans",    32'(bus.HTRANS),    32'h0);
    check("rst_haddr",     bus.HADDR,          32'h0);
    check("rst_hwrite",    32'(bus.HWRITE),    32'h0);
    check("rst_hsize",     32'(bus.HSIZE),     32'h0);
    check("rst_hwdata",    bus.HWDATA,         32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
    check("rst_hburst",    32'(bus.HBURST),    32'h0);
    check("rst_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
    check("rst_hprot",     32'(bus.HPROT),     32'h3);
    HRESET = 1'b0;

    // ---- Zero-wait back-to-back: write then read of 0x1000 ----
    drive_cmd(1'b1, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF);
    #1 check("b2b_ready_empty", 32'(bus.cmd_ready), 32'h1);
    tick();                                              // write accepted
    check("b2b_wr_htrans", 32'(bus.HTRANS), 32'h2);
    check("b2b_wr_haddr",  bus.HADDR,       32'h0000_1000);
    check("b2b_wr_hwrite", 32'(bus.HWRITE), 32'h1);
    check("b2b_wr_hsize",  32'(bus.HSIZE),  32'h2);
    drive_cmd(1'b0, 2'd2, 32'h0000_1000, 32'h0);
    #1 check("b2b_ready_full_hready", 32'(bus.cmd_ready), 32'h1);
    tick();                                              // read accepted, write in data phase
    check("b2b_rd_htrans", 32'(bus.HTRANS),    32'h2);
    check("b2b_rd_haddr",  bus.HADDR,          32'h0000_1000);
    check("b2b_rd_hwrite", 32'(bus.HWRITE),    32'h0);
    check("b2b_hwdata",    bus.HWDATA,         32'hDEAD_BEEF);
    check("b2b_no_rsp",    32'(bus.rsp_valid), 32'h0);
    no_cmd();
    tick();                                              // write completes
    check("b2b_wr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("b2b_wr_rsp_err",   32'(bus.rsp_err),   32'h0);
    check("b2b_wr_rsp_rdata", bus.rsp_rdata,      32'h0);
    check("b2b_idle_htrans",  32'(bus.HTRANS),    32'h0);
    bus.HRDATA = 32'hDEAD_BEEF;
    tick();                                              // read completes
    check("b2b_rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("b2b_rd_rsp_rdata", bus.rsp_rdata,      32'hDEAD_BEEF);
    check("b2b_rd_rsp_err",   32'(bus.rsp_err),   32'h0);
    bus.HRDATA = '0;
    tick();
    check("b2b_rsp_done", 32'(bus.rsp_valid), 32'h0);

    // ---- Wait states: read 0x20 stalled 3 cycles, read 0x24 queued behind it ----
    drive_cmd(1'b0, 2'd2, 32'h0000_0020, 32'h0);
    tick();                                              // accept edge
    check("ws_a_haddr", bus.HADDR, 32'h0000_0020);
    drive_cmd(1'b0, 2'd2, 32'h0000_0024, 32'h0);
    tick();
    no_cmd();
    bus.HREADY = 1'b0;
    #1 check("ws_ready_low", 32'(bus.cmd_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_hold_haddr",  bus.HADDR,          32'h0000_0024);
      check("ws_hold_htrans", 32'(bus.HTRANS),    32'h2);
      check("ws_hold_rsp",    32'(bus.rsp_valid), 32'h0);
      check("ws_hold_ready",  32'(bus.cmd_ready), 32'h0);
    end
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h1234_5678;
    tick();                                              // 5th edge after accept
    check("ws_rsp0_valid",  32'(bus.rsp_valid), 32'h1);
    check("ws_rsp0_rdata",  bus.rsp_rdata,      32'h1234_5678);
    check("ws_after_htrans", 32'(bus.HTRANS),   32'h0);
    bus.HRDATA = 32'h0000_ABCD;
    tick();
    check("ws_rsp1_valid", 32'(bus.rsp_valid), 32'h1);
    check("ws_rsp1_rdata", bus.rsp_rdata,      32'h0000_ABCD);
    bus.HRDATA = '0;
    tick();
    check("ws_rsp_done", 32'(bus.rsp_valid), 32'h0);

    // ---- Size and alignment ----
    drive_cmd(1'b1, 2'd1, 32'h0000_0103, 32'h5566_0000);
    tick();
    check("al_half_haddr", bus.HADDR,      32'h0000_0102);
    check("al_half_hsize", 32'(bus.HSIZE), 32'h1);
    drive_cmd(1'b1, 2'd2, 32'h0000_0107, 32'h0102_0304);
    tick();
    check("al_word_haddr", bus.HADDR,      32'h0000_0104);
    check("al_word_hsize", 32'(bus.HSIZE), 32'h2);
    drive_cmd(1'b1, 2'd0, 32'h0000_0105, 32'h0000_7700);
    tick();
    check("al_byte_haddr", bus.HADDR,      32'h0000_0105);
    check("al_byte_hsize", 32'(bus.HSIZE), 32'h0);
    drive_cmd(1'b1, 2'd3, 32'h0000_010B, 32'hA5A5_A5A5);
    tick();
    check("al_sz3_haddr", bus.HADDR,      32'h0000_0108);
    check("al_sz3_hsize", 32'(bus.HSIZE), 32'h2);
    no_cmd();
    tick();
    tick();
    check("al_last_rsp",   32'(bus.rsp_valid), 32'h1);
    check("al_last_err",   32'(bus.rsp_err),   32'h0);
    tick();
    check("al_rsp_done",   32'(bus.rsp_valid), 32'h0);

    // ---- Two-cycle ERROR on write 0xF000 with read 0xF004 queued ----
    drive_cmd(1'b1, 2'd2, 32'h0000_F000, 32'h1111_2222);
    tick();
    drive_cmd(1'b0, 2'd2, 32'h0000_F004, 32'h0);
    tick();                                              // write in data phase, read in address phase
    no_cmd();
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    #1 check("err1_ready", 32'(bus.cmd_ready), 32'h0);
    check("err1_htrans", 32'(bus.HTRANS), 32'h2);
    check("err1_haddr",  bus.HADDR,       32'h0000_F004);
    tick();                                              // end of first ERROR cycle
    bus.HREADY = 1'b1;
`ifdef AHB_MASTER_ERR_CANCEL_EN
    check("err2_htrans_cancel", 32'(bus.HTRANS), 32'h0);
`else
    check("err2_htrans_keep",   32'(bus.HTRANS), 32'h2);
    check("err2_haddr_keep",    bus.HADDR,       32'h0000_F004);
`endif
    tick();                                              // errored write completes
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'hCAFE_F00D;
    check("err_wr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("err_wr_rsp_err",   32'(bus.rsp_err),   32'h1);
    check("err_wr_rsp_rdata", bus.rsp_rdata,      32'h0);
    tick();
`ifdef AHB_MASTER_ERR_CANCEL_EN
    check("err_rd_cancel_valid", 32'(bus.rsp_valid), 32'h1);
    check("err_rd_cancel_err",   32'(bus.rsp_err),   32'h1);
    check("err_rd_cancel_rdata", bus.rsp_rdata,      32'h0);
`else
    check("err_rd_valid", 32'(bus.rsp_valid), 32'h1);
    check("err_rd_err",   32'(bus.rsp_err),   32'h0);
    check("err_rd_rdata", bus.rsp_rdata,      32'hCAFE_F00D);
`endif
    bus.HRDATA = '0;
    tick();
    check("err_rsp_done", 32'(bus.rsp_valid), 32'h0);

    // ---- Reset during a stalled data phase ----
    drive_cmd(1'b0, 2'd2, 32'h0000_0040, 32'h0);
    tick();
    drive_cmd(1'b0, 2'd2, 32'h0000_0044, 32'h0);
    tick();
    no_cmd();
    bus.HREADY = 1'b0;
    tick();
    HRESET = 1'b1;
    tick();
    check("rstx_htrans",    32'(bus.HTRANS),    32'h0);
    check("rstx_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    HRESET     = 1'b0;
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstx_no_stale_rsp", 32'(bus.rsp_valid), 32'h0);
      check("rstx_idle_htrans",  32'(bus.HTRANS),    32'h0);
    end
    bus.HRDATA = '0;
    drive_cmd(1'b1, 2'd2, 32'h0000_0080, 32'h0BAD_F00D);
    tick();
    check("rstx_new_htrans", 32'(bus.HTRANS), 32'h2);
    check("rstx_new_haddr",  bus.HADDR,       32'h0000_0080);
    no_cmd();
    tick();
    check("rstx_new_hwdata", bus.HWDATA, 32'h0BAD_F00D);
    tick();
    check("rstx_new_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("rstx_new_rsp_err",   32'(bus.rsp_err),   32'h0);

    // ---- Idle bus ----
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_htrans", 32'(bus.HTRANS),    32'h0);
      check("idle_rsp",    32'(bus.rsp_valid), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master_port.md
Name: ahb_lite_master_port

Overview:
- Single-initiator AHB-Lite master. Converts a valid/ready command stream into pipelined AHB-Lite SINGLE transfers.
- Returns one response per command, in order.
- Sits between CPU-side peripherals or DMA logic and the AHB-Lite interconnect.
- Counterpart to the existing AHB-Lite slaves (block RAM and peripherals), and used by their testbenches as the driving initiator.

Parameters:
- HPROT_VAL, 4'b0011: constant value driven on HPROT (data, privileged).
- ADDR_WIDTH, 32: command address width; upper HADDR bits are zero-extended.

Ports:
- HCLK in 1: clock.
- HRESET in 1: synchronous, active-high reset.
- cmd_valid in 1: command present.
- cmd_ready out 1: command accepted on the edge where cmd_valid&cmd_ready.
- cmd_write in 1: 1 = write, 0 = read.
- cmd_size in 2: 0 = byte, 1 = halfword, 2 = word (3 is treated as 2).
- cmd_addr in ADDR_WIDTH: byte address.
- cmd_wdata in 32: write data, lane-aligned by the caller.
- rsp_valid out 1: one-cycle response pulse; there is no backpressure.
- rsp_rdata out 32: read data; 0 for writes.
- rsp_err out 1: slave returned ERROR, or the transfer was cancelled.
- HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HBURST out 3, HPROT out 4, HMASTLOCK out 1, HWDATA out 32: AHB-Lite master outputs.
- HREADY in 1, HRESP in 1, HRDATA in 32: AHB-Lite master inputs.

Behaviour:
- All outputs are registered except cmd_ready.
- Reset values: HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=3'b000, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. HBURST is constant 3'b000, HMASTLOCK constant 0, HPROT constant HPROT_VAL.
- Two-stage pipeline:
  - A-stage holds the address phase: a_valid, which drives HTRANS[1].
  - D-stage holds the data phase: d_valid, d_write.
- cmd_ready = ~a_valid | HREADY.
- On the edge where HREADY=1:
  - A moves to D.
  - HWDATA is loaded from the A-stage's stored wdata.
  - A loads the new command if one is accepted; otherwise A clears and HTRANS becomes IDLE.
- When HREADY=0, A and D hold. HADDR, HTRANS, HWRITE, HSIZE and HWDATA stay stable.
- Command accept also occurs when a_valid=0, independent of HREADY.
- Address is aligned per size on issue:
  - halfword: HADDR[0]=0;
  - word: HADDR[1:0]=0;
  - HSIZE={1'b0,size}.
- Transfers are always NONSEQ (2'b10), never SEQ or BUSY.
- Completion: d_valid & HREADY at an edge.
  - Next cycle: rsp_valid=1 and rsp_err=HRESP.
  - rsp_rdata=HRDATA for reads, 0 for writes.
  - If no completion occurs, rsp_valid=0.
- Latency with zero wait states:
  - command accepted at edge E0;
  - address phase ends at E1;
  - data phase ends at E2;
  - rsp_valid is high during the cycle after E2.
  - Each slave wait state adds one cycle.
- Throughput: one transfer per cycle with zero waits.
- Error response: the first ERROR cycle (HRESP=1, HREADY=0) only holds the pipeline. Completion is taken on the second cycle (HRESP=1, HREADY=1), giving rsp_err=1.
- Simultaneous events:
  - a completion and a new issue on the same edge are both performed;
  - an empty D-stage with HREADY=1 is legal.
- Reset mid-transfer: outstanding A/D entries are dropped with no response, and the bus returns to IDLE from the cycle after reset. A slave wait state in progress is abandoned.

Optional Feature:
- Macro: AHB_MASTER_ERR_CANCEL_EN.
- Defined:
  - In the first ERROR cycle (d_valid, HRESP=1, HREADY=0), if a_valid=1 the A-stage is cancelled at that edge.
  - HTRANS is driven IDLE in the second ERROR cycle.
  - The cancelled command receives its own response (rsp_valid=1, rsp_err=1, rsp_rdata=0) in the cycle after the errored transfer's response.
  - cmd_ready=0 during the first ERROR cycle.
- Not defined: the pending address is kept and issued normally after the error.

Test Plan:
- Zero-wait back-to-back: write 0x1000=0xDEADBEEF, then read 0x1000, slave HREADY=1 -> HTRANS NONSEQ on two consecutive cycles; HWDATA=0xDEADBEEF one cycle after the write's address phase; two rsp pulses on consecutive cycles; second has rsp_rdata=0xDEADBEEF, rsp_err=0.
- Wait states: read 0x20 with HREADY low for 3 cycles in the data phase -> next HADDR/HTRANS held stable, cmd_ready=0 while a_valid; rsp_valid 5 cycles after accept.
- Size/align: halfword write at 0x103 -> HADDR=0x102, HSIZE=3'b001; word at 0x107 -> HADDR=0x104, HSIZE=3'b010.
- Error: slave returns 2-cycle ERROR on a write to 0xF000 -> one rsp with rsp_err=1; with AHB_MASTER_ERR_CANCEL_EN, a queued read gets HTRANS=IDLE in the 2nd cycle and rsp_err=1 next; without it, the read completes normally.
- Reset: assert HRESET during a data phase with HREADY=0 -> next cycle HTRANS=00, rsp_valid=0; no stale response after deassert; a new command works.
- Idle bus: no cmd_valid for 10 cycles -> HTRANS stays 00, rsp_valid stays 0.
